// File: rtl/demux32_1to2_buf_if.sv
// Handshake bundle between one producer and the two consumers of the
// buffered 1-to-2 word router.
//   slave  : the router's view of the bundle
//   master : the environment's view (producer plus both consumers)
interface demux32_1to2_buf_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0;
    logic             out0_valid;
    logic             out0_ready;
    logic [CW-1:0]    count0;

    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [CW-1:0]    count1;

    modport slave (
        input  in, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0, out0_valid, count0, out1, out1_valid, count1
    );

    modport master (
        output in, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0, out0_valid, count0, out1, out1_valid, count1
    );
endinterface

// File: rtl/demux32_1to2_buf.sv
// Buffered 1-to-2 word router. Each incoming word is steered by in_sel
// into one of two independent DEPTH-entry FIFOs, each drained by its own
// consumer under valid/ready, so a stalled consumer never blocks or
// corrupts the other one's traffic.
module demux32_1to2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    demux32_1to2_buf_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Per-FIFO views so both FIFOs can be built by one generate loop.
    logic             out_ready_arr [2];
    logic             full_arr      [2];
    logic [WIDTH-1:0] head_arr      [2];
    logic [CW-1:0]    count_arr     [2];
    logic             in_ready;

    assign out_ready_arr[0] = bus.out0_ready;
    assign out_ready_arr[1] = bus.out1_ready;

    // Acceptance looks only at the selected FIFO's registered fill level,
    // so a pop in the same cycle never frees room for a push (no
    // combinational path from the consumer ready signals to in_ready).
    assign in_ready     = rst_n && !full_arr[bus.in_sel];
    assign bus.in_ready = in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    count_reg;
            logic [CW-1:0]    count_next;
            logic             push;
            logic             pop;

            assign push = bus.in_valid && in_ready && (bus.in_sel == 1'(gi));
            // A ready from the consumer while empty is simply ignored.
            assign pop  = (count_reg != '0) && out_ready_arr[gi];

            // Occupancy: push alone grows, pop alone shrinks, both cancel.
            always_comb begin
                count_next = count_reg;
                if (push && !pop) begin
                    count_next = count_reg + 1'b1;
                end else if (pop && !push) begin
                    count_next = count_reg - 1'b1;
                end
            end

            // Storage write; contents need no reset since the head is
            // masked to zero whenever the FIFO is empty.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= bus.in;
                end
            end

            // Pointer and occupancy state; reset drops all buffered words.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    count_reg <= count_next;
                end
            end

            assign full_arr[gi]  = (count_reg == CW'(DEPTH));
            assign count_arr[gi] = count_reg;
            assign head_arr[gi]  = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
        end
    endgenerate

    assign bus.out0       = head_arr[0];
    assign bus.out1       = head_arr[1];
    assign bus.out0_valid = (count_arr[0] != '0);
    assign bus.out1_valid = (count_arr[1] != '0);
    assign bus.count0     = count_arr[0];
    assign bus.count1     = count_arr[1];
endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Bench for the buffered 1-to-2 word router. The driver decides from a
// queue-per-output reference model whether each word is accepted and
// pushes accepted words onto that output's expected queue; an independent
// monitor compares every DUT output against the queue heads each cycle and
// pops when the consumer takes a word.
module tb_demux32_1to2_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    demux32_1to2_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux32_1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted but not yet consumed, per output.
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: runs 2 time units after every falling edge, with inputs
    // for the coming rising edge already stable.
    task automatic monitor_step();
        int   n0;
        int   n1;
        logic exp_ready;
        n0 = q0.size();
        n1 = q1.size();
        exp_ready = rst_n && (bus.in_sel ? (n1 != DEPTH) : (n0 != DEPTH));
        chk("in_ready",   bus.in_ready,   exp_ready);
        chk("count0",     bus.count0,     n0);
        chk("count1",     bus.count1,     n1);
        chk("out0_valid", bus.out0_valid, n0 != 0);
        chk("out1_valid", bus.out1_valid, n1 != 0);
        chk("out0",       bus.out0,       (n0 != 0) ? q0[0] : 32'h0);
        chk("out1",       bus.out1,       (n1 != 0) ? q1[0] : 32'h0);
        $display("mon t=%0t rst_n=%0b in_rdy=%0b c0=%0d c1=%0d out0=%h/%0b out1=%h/%0b",
                 $time, rst_n, bus.in_ready, bus.count0, bus.count1,
                 bus.out0, bus.out0_valid, bus.out1, bus.out1_valid);
        if (n0 != 0 && bus.out0_ready) void'(q0.pop_front());
        if (n1 != 0 && bus.out1_ready) void'(q1.pop_front());
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            monitor_step();
        end
    end

    // One bus cycle: drive at the falling edge, decide acceptance from the
    // model's pre-edge occupancy (a full FIFO refuses even if popped), and
    // queue the word once the monitor has taken its pops for this cycle.
    task automatic cycle(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1, output logic acc);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in         = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        #1;
        acc = v && rst_n && ((sel ? q1.size() : q0.size()) != DEPTH);
        #2;
        if (acc) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
    endtask

    // Asynchronous reset between edges, with immediate output checks.
    task automatic apply_reset();
        logic acc;
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #2;
        chk("rst_out0_valid", bus.out0_valid, 1'b0);
        chk("rst_count0",     bus.count0,     32'd0);
        chk("rst_out0",       bus.out0,       32'h0);
        chk("rst_in_ready",   bus.in_ready,   1'b0);
        cycle(1'b1, 1'b0, 32'hBAD0_0001, 1'b1, 1'b1, acc);
        cycle(1'b1, 1'b1, 32'hBAD0_0002, 1'b1, 1'b1, acc);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic        p_valid;
        logic        p_sel;
        logic [31:0] p_data;
        int          words;
        int          cyc;
        int          p0;
        int          p1;

        bus.in         = '0;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single route, both consumers ready.
        cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, acc);
        cycle(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, acc);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

        // Backpressure on output 1: third word refused until room appears.
        cycle(1'b1, 1'b1, 32'h1, 1'b1, 1'b0, acc);
        cycle(1'b1, 1'b1, 32'h2, 1'b1, 1'b0, acc);
        cycle(1'b1, 1'b1, 32'h3, 1'b1, 1'b0, acc);
        cycle(1'b1, 1'b1, 32'h3, 1'b1, 1'b1, acc);
        cycle(1'b1, 1'b1, 32'h3, 1'b1, 1'b0, acc);
        repeat (3) cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, acc);

        // Full FIFO0 popped and pushed in the same cycle: push refused.
        cycle(1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, acc);
        cycle(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, acc);

        // Isolation: refill FIFO0 and stall it while output 1 streams.
        cycle(1'b1, 1'b0, 32'hB0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 32'h10 + i, 1'b0, 1'b1, acc);
            chk("stream_accept", acc, 1'b1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);

        // Reset with FIFO0 holding two words; they must never reappear.
        apply_reset();
        cycle(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, acc);
        apply_reset();
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

        // Randomised traffic with a held word while refused.
        words   = 0;
        cyc     = 0;
        p_valid = 1'b0;
        p_sel   = 1'b0;
        p_data  = '0;
        p0      = 50;
        p1      = 50;
        while (words < 100 && cyc < 3000) begin
            if (cyc % 16 == 0) begin
                p0 = $urandom_range(0, 100);
                p1 = $urandom_range(0, 100);
            end
            if (!p_valid) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_sel   = 1'($urandom_range(0, 1));
                p_data  = $urandom;
            end
            cycle(p_valid, p_sel, p_data,
                  $urandom_range(0, 99) < p0, $urandom_range(0, 99) < p1, acc);
            if (acc) begin
                words++;
                p_valid = 1'b0;
            end
            cyc++;
        end
        chk("random_words", words, 100);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
